// File: rtl/wb_crossbar_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_crossbar_pkg : arbiter state type, Wishbone CTI/BTE codes, address decode
// Rev 1.0
// ----------------------------------------------------------------------------
package wb_crossbar_pkg;

  localparam int c_MAX_SLAVES = 16;
  localparam int c_MAX_AW     = 64;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] c_CTI_CONST   = 3'b001;
  localparam logic [2:0] c_CTI_INCR    = 3'b010;
  localparam logic [2:0] c_CTI_EOB     = 3'b111;
  localparam logic [1:0] c_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] c_BTE_WRAP4   = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } dec_t;

  typedef logic [c_MAX_SLAVES-1:0][c_MAX_AW-1:0] range_vec_t;

  // Scans from the top so the lowest matching slave index is the one kept.
  function automatic dec_t wb_decode(input logic [c_MAX_AW-1:0] adr,
                                     input range_vec_t          base,
                                     input range_vec_t          limit,
                                     input int                  n_slaves);
    dec_t d;
    d = '0;
    for (int k = c_MAX_SLAVES - 1; k >= 0; k--) begin
      if (k < n_slaves && adr >= base[k] && adr <= limit[k]) begin
        d.valid = 1'b1;
        d.idx   = 4'(k);
      end
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_crossbar_rr_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_crossbar_rr_arb : per-slave round-robin arbiter; watchdog under WB_CROSSBAR_TIMEOUT_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_crossbar_rr_arb
  import wb_crossbar_pkg::*;
#(
  parameter int  N_MASTERS      = 2,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int c_MW           = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [N_MASTERS-1:0] i_cyc,
  input  logic [N_MASTERS-1:0] i_stb,
  input  logic                 i_s_ack,
  input  logic                 i_s_err,
  output logic                 o_owned,
  output logic                 o_grant,
  output logic                 o_timeout,
  output logic [c_MW-1:0]      o_owner
);

  arb_state_e      r_state, w_state_nxt;
  logic [c_MW-1:0] r_owner, w_owner_nxt;
  logic [c_MW-1:0] r_last, w_last_nxt;
  logic [c_MW-1:0] w_pick, w_cand;
  logic            w_pick_vld;
  logic            r_rdy;
  logic            w_tmo;

  // Highest offset first so the candidate nearest to last_grant+1 wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_last;
    w_cand     = r_last;
    for (int i = N_MASTERS; i >= 1; i--) begin
      w_cand = c_MW'((int'(r_last) + i) % N_MASTERS);
      if (i_req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (r_rdy && w_pick_vld) begin
          w_state_nxt = ARB_OWNED;
          w_owner_nxt = w_pick;
        end
      end
      ARB_OWNED: begin
        if (!i_cyc[r_owner] || w_tmo) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // r_rdy holds off granting for one edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_last  <= c_MW'(N_MASTERS - 1);
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_rdy   <= 1'b1;
    end
  end

`ifdef WB_CROSSBAR_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TW-1:0] r_cnt;

  assign w_tmo = (r_state == ARB_OWNED) && i_cyc[r_owner] &&
                 (r_cnt == c_TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state != ARB_OWNED || w_tmo || i_s_ack || i_s_err)
      r_cnt <= '0;
    else if (i_stb[r_owner])
      r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign w_unused_tmo = ^{i_stb, i_s_ack, i_s_err, TIMEOUT_CYCLES[0]};
`endif

  assign o_owned   = (r_state == ARB_OWNED);
  assign o_grant   = o_owned && !w_tmo;
  assign o_timeout = w_tmo;
  assign o_owner   = r_owner;

endmodule
`default_nettype wire

// File: rtl/wb_crossbar_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_crossbar_rr : N x M Wishbone crossbar, per-slave round-robin arbitration
// Rev 1.0 -- define WB_CROSSBAR_TIMEOUT_EN to add per-slave watchdogs
// ----------------------------------------------------------------------------
module wb_crossbar_rr
  import wb_crossbar_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 2,
  parameter int N_SLAVES       = 2,
  parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_w,
  input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0] m_sel,
  input  logic [N_MASTERS*3-1:0]               m_cti,
  input  logic [N_MASTERS*2-1:0]               m_bte,
  input  logic [N_MASTERS-1:0]                 m_cyc,
  input  logic [N_MASTERS-1:0]                 m_stb,
  input  logic [N_MASTERS-1:0]                 m_we,
  output logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_r,
  output logic [N_MASTERS-1:0]                 m_ack,
  output logic [N_MASTERS-1:0]                 m_err,
  output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]    s_adr,
  output logic [N_SLAVES*WB_DATA_WIDTH-1:0]    s_dat_w,
  output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]  s_sel,
  output logic [N_SLAVES*3-1:0]                s_cti,
  output logic [N_SLAVES*2-1:0]                s_bte,
  output logic [N_SLAVES-1:0]                  s_cyc,
  output logic [N_SLAVES-1:0]                  s_stb,
  output logic [N_SLAVES-1:0]                  s_we,
  input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]    s_dat_r,
  input  logic [N_SLAVES-1:0]                  s_ack,
  input  logic [N_SLAVES-1:0]                  s_err
);

  localparam int c_AW   = WB_ADDR_WIDTH;
  localparam int c_DW   = WB_DATA_WIDTH;
  localparam int c_SELW = WB_DATA_WIDTH / 8;
  localparam int c_MW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  range_vec_t                          w_base, w_limit;
  dec_t                                w_dec [N_MASTERS];
  logic [N_SLAVES-1:0][N_MASTERS-1:0]  w_req;
  logic [N_MASTERS-1:0]                w_busy, w_unmapped, r_uerr;
  logic [N_SLAVES-1:0]                 w_owned, w_grant, w_tmo;
  logic [c_MW-1:0]                     w_owner [N_SLAVES];

  // Slave 0 occupies the most-significant {base,limit} pair.
  for (genvar k = 0; k < c_MAX_SLAVES; k++) begin : g_rng
    if (k < N_SLAVES) begin : g_map
      assign w_base[k]  = c_MAX_AW'(ADDR_RANGES[2*(N_SLAVES-k)*c_AW-1 -: c_AW]);
      assign w_limit[k] = c_MAX_AW'(ADDR_RANGES[(2*(N_SLAVES-k)-1)*c_AW-1 -: c_AW]);
    end else begin : g_unmap
      assign w_base[k]  = '0;
      assign w_limit[k] = '0;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int k = 0; k < N_SLAVES; k++)
      for (int m = 0; m < N_MASTERS; m++)
        if (w_owned[k] && w_owner[k] == c_MW'(m)) w_busy[m] = 1'b1;
  end

  // An owning master is kept out of every other arbiter until its cyc drops.
  always_comb begin
    w_req      = '0;
    w_unmapped = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      w_dec[m] = wb_decode(c_MAX_AW'(m_adr[m*c_AW +: c_AW]), w_base, w_limit, N_SLAVES);
      if (m_cyc[m] && m_stb[m] && !w_busy[m]) begin
        if (w_dec[m].valid) begin
          for (int k = 0; k < N_SLAVES; k++)
            if (w_dec[m].idx == 4'(k)) w_req[k][m] = 1'b1;
        end else begin
          w_unmapped[m] = 1'b1;
        end
      end
    end
  end

  // Self-masking so a held unmapped strobe errors on alternate cycles only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_uerr <= '0;
    else     r_uerr <= w_unmapped & ~r_uerr;
  end

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_arb
    wb_crossbar_rr_arb #(
      .N_MASTERS      (N_MASTERS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_req[k]),
      .i_cyc     (m_cyc),
      .i_stb     (m_stb),
      .i_s_ack   (s_ack[k]),
      .i_s_err   (s_err[k]),
      .o_owned   (w_owned[k]),
      .o_grant   (w_grant[k]),
      .o_timeout (w_tmo[k]),
      .o_owner   (w_owner[k])
    );
  end

  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_bte   = '0;
    s_cyc   = '0;
    s_stb   = '0;
    s_we    = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (w_grant[k]) begin
        s_adr[k*c_AW +: c_AW]       = m_adr[int'(w_owner[k])*c_AW +: c_AW];
        s_dat_w[k*c_DW +: c_DW]     = m_dat_w[int'(w_owner[k])*c_DW +: c_DW];
        s_sel[k*c_SELW +: c_SELW]   = m_sel[int'(w_owner[k])*c_SELW +: c_SELW];
        s_cti[k*3 +: 3]             = m_cti[int'(w_owner[k])*3 +: 3];
        s_bte[k*2 +: 2]             = m_bte[int'(w_owner[k])*2 +: 2];
        s_cyc[k]                    = m_cyc[w_owner[k]];
        s_stb[k]                    = m_stb[w_owner[k]];
        s_we[k]                     = m_we[w_owner[k]];
      end
    end
  end

  always_comb begin
    m_dat_r = '0;
    m_ack   = '0;
    m_err   = r_uerr;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (w_grant[k]) begin
        m_dat_r[int'(w_owner[k])*c_DW +: c_DW] = s_dat_r[k*c_DW +: c_DW];
        m_ack[w_owner[k]] = s_ack[k];
        if (s_err[k]) m_err[w_owner[k]] = 1'b1;
      end
      if (w_tmo[k]) m_err[w_owner[k]] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_crossbar_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_crossbar_rr : directed bench, two masters / two slaves (0x0000-0x0FFF, 0x1000-0x1FFF)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_wb_crossbar_rr;
  import wb_crossbar_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 2;
  localparam int NS = 2;
  localparam logic [2*NS*AW-1:0] RANGES = {32'h0000_0000, 32'h0000_0FFF,
                                           32'h0000_1000, 32'h0000_1FFF};
  localparam logic [DW-1:0] S0_DATA = 32'h5A5A_0000;
  localparam logic [DW-1:0] S1_DATA = 32'hC0DE_0001;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_w;
  logic [NM*4-1:0]   m_sel;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*DW-1:0]  m_dat_r;
  logic [NM-1:0]     m_ack, m_err;
  logic [NS*AW-1:0]  s_adr;
  logic [NS*DW-1:0]  s_dat_w;
  logic [NS*4-1:0]   s_sel;
  logic [NS*3-1:0]   s_cti;
  logic [NS*2-1:0]   s_bte;
  logic [NS-1:0]     s_cyc, s_stb, s_we;
  logic [NS*DW-1:0]  s_dat_r;
  logic [NS-1:0]     s_ack, s_err;
  logic [NS-1:0]     ack_en;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  // Zero-wait slaves with per-slave ack enable.
  assign s_ack   = s_cyc & s_stb & ack_en;
  assign s_err   = '0;
  assign s_dat_r = {S1_DATA, S0_DATA};

  wb_crossbar_rr #(
    .WB_ADDR_WIDTH  (AW),
    .WB_DATA_WIDTH  (DW),
    .N_MASTERS      (NM),
    .N_SLAVES       (NS),
    .ADDR_RANGES    (RANGES),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_adr   (m_adr),
    .m_dat_w (m_dat_w),
    .m_sel   (m_sel),
    .m_cti   (m_cti),
    .m_bte   (m_bte),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_dat_r (m_dat_r),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .s_adr   (s_adr),
    .s_dat_w (s_dat_w),
    .s_sel   (s_sel),
    .s_cti   (s_cti),
    .s_bte   (s_bte),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_dat_r (s_dat_r),
    .s_ack   (s_ack),
    .s_err   (s_err)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic [31:0] adr, input logic cyc,
                       input logic we, input logic [31:0] dat,
                       input logic [2:0] cti, input logic [1:0] bte);
    m_adr[m*AW +: AW]   = adr;
    m_dat_w[m*DW +: DW] = dat;
    m_sel[m*4 +: 4]     = 4'hF;
    m_cti[m*3 +: 3]     = cti;
    m_bte[m*2 +: 2]     = bte;
    m_cyc[m]            = cyc;
    m_stb[m]            = cyc;
    m_we[m]             = we;
  endtask

  task automatic idle(input int m);
    drive(m, 32'h0, 1'b0, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ack_en  = 2'b11;
    m_adr = '0; m_dat_w = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    m_cyc = '0; m_stb = '0; m_we = '0;

    // Reset with a live request: nothing may leak out.
    rst = 1'b1;
    drive(0, 32'h10, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    drive(1, 32'h8000, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    repeat (2) @(posedge clk);
    sample();
    check_val("rst_s_cyc", s_cyc, 0);
    check_val("rst_s_stb", s_stb, 0);
    check_val("rst_m_ack", m_ack, 0);
    check_val("rst_m_err", m_err, 0);
    step(); idle(0); idle(1); rst = 1'b0;
    step(); step();

    // Single write to slave 1.
    drive(0, 32'h1004, 1'b1, 1'b1, 32'hDEADBEEF, c_CTI_CLASSIC, c_BTE_LINEAR);
    sample();
    check_val("t1_s1_stb_wait", s_stb[1], 0);
    check_val("t1_m0_ack_wait", m_ack[0], 0);
    step(); sample();
    check_val("t1_s1_stb", s_stb[1], 1);
    check_val("t1_s1_adr", s_adr[AW +: AW], 32'h1004);
    check_val("t1_s1_dat", s_dat_w[DW +: DW], 32'hDEADBEEF);
    check_val("t1_s1_we", s_we[1], 1);
    check_val("t1_m0_ack", m_ack[0], 1);
    check_val("t1_m0_dat_r", m_dat_r[0 +: DW], S1_DATA);
    check_val("t1_s0_idle", s_cyc[0], 0);
    step(); idle(0); sample();
    check_val("t1_s1_release", s_cyc[1], 0);
    step(); step();

    // Contention on slave 0: m0, then m1, then m0 again.
    drive(0, 32'h10, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    drive(1, 32'h20, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    sample();
    check_val("t2_no_grant_yet", s_cyc[0], 0);
    step(); sample();
    check_val("t2_first_adr", s_adr[0 +: AW], 32'h10);
    check_val("t2_m0_ack", m_ack, 2'b01);
    check_val("t2_m0_dat_r", m_dat_r[0 +: DW], S0_DATA);
    step(); idle(0); sample();
    check_val("t2_release_ack", m_ack, 0);
    step(); sample();
    check_val("t2_arb_gap", s_cyc[0], 0);
    step(); sample();
    check_val("t2_second_adr", s_adr[0 +: AW], 32'h20);
    check_val("t2_m1_ack", m_ack, 2'b10);
    check_val("t2_m1_dat_r", m_dat_r[DW +: DW], S0_DATA);
    step(); idle(1); sample();
    step();
    drive(0, 32'h30, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    drive(1, 32'h40, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    step(); sample();
    check_val("t2_third_adr", s_adr[0 +: AW], 32'h30);
    check_val("t2_m0_again", m_ack, 2'b01);
    step(); idle(0); idle(1);
    step(); step();

    // Unmapped access, strobe held two cycles.
    drive(0, 32'h8000, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    sample();
    check_val("t3_err_not_yet", m_err[0], 0);
    step(); sample();
    check_val("t3_err_pulse", m_err, 2'b01);
    check_val("t3_no_slave", s_cyc, 0);
    step(); idle(0); sample();
    check_val("t3_err_no_repeat", m_err[0], 0);
    step(); sample();
    check_val("t3_err_quiet", m_err, 0);
    step();

    // Owner moves its address into slave 1's range while holding cyc.
    drive(0, 32'h100, 1'b1, 1'b0, 32'h0, c_CTI_CONST, c_BTE_WRAP4);
    step(); sample();
    check_val("t4_s0_owned", s_cyc, 2'b01);
    check_val("t4_bte_fwd", s_bte[0 +: 2], c_BTE_WRAP4);
    step();
    drive(0, 32'h1000, 1'b1, 1'b0, 32'h0, c_CTI_CONST, c_BTE_WRAP4);
    sample();
    check_val("t4_route_held", s_cyc, 2'b01);
    check_val("t4_adr_follows", s_adr[0 +: AW], 32'h1000);
    check_val("t4_no_err", m_err, 0);
    step(); sample();
    check_val("t4_route_held2", s_cyc, 2'b01);
    step(); idle(0);
    step(); step();

    // Unresponsive slave 0 with m1 queued behind m0.
    ack_en[0] = 1'b0;
    drive(0, 32'h40, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    step();
    drive(1, 32'h44, 1'b1, 1'b0, 32'h0, c_CTI_CLASSIC, c_BTE_LINEAR);
    for (int i = 0; i < 7; i++) step();
    sample();
    check_val("t5_stall_no_err", m_err, 0);
    check_val("t5_stall_cyc", s_cyc[0], 1);
    check_val("t5_waiter_no_ack", m_ack[1], 0);
    step(); sample();
`ifdef WB_CROSSBAR_TIMEOUT_EN
    check_val("t5_tmo_err", m_err, 2'b01);
    check_val("t5_tmo_cyc_low", s_cyc[0], 0);
    check_val("t5_tmo_no_ack", m_ack, 0);
    step(); idle(0); ack_en[0] = 1'b1; sample();
    check_val("t5_idle_gap", s_cyc[0], 0);
    check_val("t5_err_once", m_err, 0);
    step(); sample();
    check_val("t5_waiter_adr", s_adr[0 +: AW], 32'h44);
    check_val("t5_waiter_ack", m_ack, 2'b10);
    step(); idle(1);
`else
    check_val("t5_hold_no_err", m_err, 0);
    check_val("t5_hold_cyc", s_cyc[0], 1);
    for (int i = 0; i < 12; i++) step();
    sample();
    check_val("t5_hold_long", s_cyc[0], 1);
    check_val("t5_hold_adr", s_adr[0 +: AW], 32'h40);
    check_val("t5_hold_waiter", m_ack[1], 0);
    ack_en[0] = 1'b1;
    step(); idle(0); idle(1);
`endif
    ack_en = 2'b11;
    step(); step();

    // Reset in the middle of an incrementing burst to slave 1.
    drive(0, 32'h1100, 1'b1, 1'b1, 32'h1111_0000, c_CTI_INCR, c_BTE_LINEAR);
    step(); sample();
    check_val("t6_burst_ack", m_ack[0], 1);
    check_val("t6_burst_cti", s_cti[3 +: 3], c_CTI_INCR);
    step();
    drive(0, 32'h1104, 1'b1, 1'b1, 32'h1111_0004, c_CTI_INCR, c_BTE_LINEAR);
    rst = 1'b1;
    #1;
    check_val("t6_rst_s_cyc", s_cyc, 0);
    check_val("t6_rst_m_ack", m_ack, 0);
    check_val("t6_rst_m_err", m_err, 0);
    step(); rst = 1'b0;
    sample();
    check_val("t6_post_rst_1", s_cyc, 0);
    step(); sample();
    check_val("t6_post_rst_2", s_cyc, 0);
    step(); sample();
    check_val("t6_regrant", s_cyc, 2'b10);
    check_val("t6_regrant_ack", m_ack, 2'b01);
    check_val("t6_regrant_adr", s_adr[AW +: AW], 32'h1104);
    step();
    drive(0, 32'h1108, 1'b1, 1'b1, 32'h1111_0008, c_CTI_EOB, c_BTE_LINEAR);
    sample();
    check_val("t6_eob_ack", m_ack[0], 1);
    check_val("t6_eob_cti", s_cti[3 +: 3], c_CTI_EOB);
    step(); idle(0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
